// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply core and its BRAM loader.
package mm_pkg;

    localparam int WIDTH             = 16;
    localparam int CHUNK_SIZE        = 4;
    localparam int INNER_DIMENSION   = 8;
    localparam int W_OUTER_DIMENSION = 16;
    localparam int I_OUTER_DIMENSION = 16;

    localparam int DATA_W  = WIDTH * CHUNK_SIZE;
    localparam int W_WORDS = INNER_DIMENSION * W_OUTER_DIMENSION / CHUNK_SIZE;
    localparam int I_WORDS = INNER_DIMENSION * I_OUTER_DIMENSION / CHUNK_SIZE;

    localparam int WB_ADDR_W    = 12;
    localparam int IN_ADDR_W    = 14;
    localparam int WEA_W        = 8;
    localparam int WB_MAX_WORDS = 4096;
    localparam int IN_MAX_WORDS = 16384;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so the counter never wraps at the terminal count.
    localparam int CNT_W = $clog2(max_int(W_WORDS, I_WORDS)) + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_I    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } loader_state_t;

endpackage

// File: rtl/mm_bram_loader_if.sv
// Valid/ready word stream feeding the BRAM loader.
interface mm_bram_loader_if;

    logic                      s_valid;
    logic [mm_pkg::DATA_W-1:0] s_data;
    logic                      s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/mm_bram_loader_bram_wr_port.sv
// Registered BRAM write-port driver: a write request in cycle n is presented in cycle n+1.
module bram_wr_port #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 6,
    parameter int DATA_W = 64,
    parameter int WEA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [CNT_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ena,
    output logic [WEA_W-1:0]  o_wea,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_din
);

    logic              r_ena;
    logic [WEA_W-1:0]  r_wea;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;

    // Enables follow the request every cycle; address and data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ena  <= 1'b0;
            r_wea  <= {WEA_W{1'b0}};
            r_addr <= {ADDR_W{1'b0}};
            r_din  <= {DATA_W{1'b0}};
        end else begin
            r_ena <= i_we;
            r_wea <= i_we ? {WEA_W{1'b1}} : {WEA_W{1'b0}};
            if (i_we) begin
                r_addr <= ADDR_W'(i_addr);
                r_din  <= i_data;
            end else begin
                r_addr <= r_addr;
                r_din  <= r_din;
            end
        end
    end

    assign o_ena  = r_ena;
    assign o_wea  = r_wea;
    assign o_addr = r_addr;
    assign o_din  = r_din;

endmodule

// File: rtl/mm_bram_loader.sv
// Streams weight then input words into the core's BRAMs, starts the core and waits for it.
module mm_bram_loader
    import mm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load_req,
    mm_bram_loader_if.slave      s,
    output logic                 o_wb_ena,
    output logic [WB_ADDR_W-1:0] o_wb_addra,
    output logic [DATA_W-1:0]    o_wb_dina,
    output logic [WEA_W-1:0]     o_wb_wea,
    output logic                 o_in_ena,
    output logic [IN_ADDR_W-1:0] o_in_addra,
    output logic [DATA_W-1:0]    o_in_dina,
    output logic [WEA_W-1:0]     o_in_wea,
    output logic                 o_core_start,
    input  logic                 i_core_done,
    output logic                 o_busy,
    output logic                 o_load_done
);

    if (W_WORDS > WB_MAX_WORDS) begin : g_wb_size_chk
        $fatal(1, "mm_bram_loader: W_WORDS exceeds weight BRAM depth");
    end
    if (I_WORDS > IN_MAX_WORDS) begin : g_in_size_chk
        $fatal(1, "mm_bram_loader: I_WORDS exceeds input BRAM depth");
    end

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_beat;
    logic              w_wb_we;
    logic              w_in_we;
    logic              r_s_ready;
    logic              r_busy;
    logic              r_core_start;
    logic              r_load_done;

    assign w_beat = r_s_ready & s.s_valid;

    // State and word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and write-request decode.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_wb_we      = 1'b0;
        w_in_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_req) begin
                    w_next_state = ST_LOAD_W;
                    w_cnt_next   = {CNT_W{1'b0}};
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                if (w_beat) begin
                    w_wb_we = 1'b1;
                    if (r_cnt == CNT_W'(W_WORDS - 1)) begin
                        w_next_state = ST_LOAD_I;
                        w_cnt_next   = {CNT_W{1'b0}};
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            ST_LOAD_I: begin
                if (w_beat) begin
                    w_in_we = 1'b1;
                    if (r_cnt == CNT_W'(I_WORDS - 1)) begin
                        w_next_state = ST_START;
                        w_cnt_next   = {CNT_W{1'b0}};
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_core_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered status outputs; core_start trails the START state so the last write lands first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_s_ready    <= (w_next_state == ST_LOAD_W) || (w_next_state == ST_LOAD_I);
            r_busy       <= (w_next_state != ST_IDLE);
            r_core_start <= (r_state == ST_START);
            r_load_done  <= (r_state == ST_WAIT_DONE) && i_core_done;
        end
    end

    assign s.s_ready    = r_s_ready;
    assign o_busy       = r_busy;
    assign o_core_start = r_core_start;
    assign o_load_done  = r_load_done;

    bram_wr_port #(
        .ADDR_W (WB_ADDR_W),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W),
        .WEA_W  (WEA_W)
    ) u_wb_port (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_wb_we),
        .i_addr (r_cnt),
        .i_data (s.s_data),
        .o_ena  (o_wb_ena),
        .o_wea  (o_wb_wea),
        .o_addr (o_wb_addra),
        .o_din  (o_wb_dina)
    );

    bram_wr_port #(
        .ADDR_W (IN_ADDR_W),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W),
        .WEA_W  (WEA_W)
    ) u_in_port (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_in_we),
        .i_addr (r_cnt),
        .i_data (s.s_data),
        .o_ena  (o_in_ena),
        .o_wea  (o_in_wea),
        .o_addr (o_in_addra),
        .o_din  (o_in_dina)
    );

endmodule

// File: tb/tb_mm_bram_loader.sv
// Scoreboard bench for mm_bram_loader: expected BRAM writes queued at drive time, checked at the ports.
module tb_mm_bram_loader;
    import mm_pkg::*;

    typedef struct packed {
        logic        is_in;
        logic [13:0] addr;
        logic [63:0] data;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 load_req;
    logic                 core_done;
    logic                 wb_ena;
    logic [WB_ADDR_W-1:0] wb_addra;
    logic [DATA_W-1:0]    wb_dina;
    logic [WEA_W-1:0]     wb_wea;
    logic                 in_ena;
    logic [IN_ADDR_W-1:0] in_addra;
    logic [DATA_W-1:0]    in_dina;
    logic [WEA_W-1:0]     in_wea;
    logic                 core_start;
    logic                 busy;
    logic                 load_done;

    mm_bram_loader_if s_if ();

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;
    int   n_start;
    int   n_done;
    bit   exp_start;

    mm_bram_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_req   (load_req),
        .s            (s_if),
        .o_wb_ena     (wb_ena),
        .o_wb_addra   (wb_addra),
        .o_wb_dina    (wb_dina),
        .o_wb_wea     (wb_wea),
        .o_in_ena     (in_ena),
        .o_in_addra   (in_addra),
        .o_in_dina    (in_dina),
        .o_in_wea     (in_wea),
        .o_core_start (core_start),
        .i_core_done  (core_done),
        .o_busy       (busy),
        .o_load_done  (load_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctl"}, {58'd0, s_if.s_ready, wb_ena, in_ena, core_start, busy, load_done}, 64'd0);
        check_eq({tag, "_wb_addra"}, 64'(wb_addra), 64'd0);
        check_eq({tag, "_wb_dina"}, wb_dina, 64'd0);
        check_eq({tag, "_wb_wea"}, 64'(wb_wea), 64'd0);
        check_eq({tag, "_in_addra"}, 64'(in_addra), 64'd0);
        check_eq({tag, "_in_dina"}, in_dina, 64'd0);
        check_eq({tag, "_in_wea"}, 64'(in_wea), 64'd0);
    endtask

    // Port monitor: pops the scoreboard on every BRAM write and tracks start/done pulses.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   nxt;
        if (rst) begin
            exp_start = 1'b0;
        end else begin
            nxt = 1'b0;
            check_eq("core_start", 64'(core_start), 64'(exp_start));
            if (core_start) n_start++;
            if (load_done) n_done++;
            check_eq("wr_excl", 64'(wb_ena & in_ena), 64'd0);
            if (wb_ena) begin
                if (sb_q.size() == 0) begin
                    check_eq("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("wb_port_sel", 64'd0, 64'(e.is_in));
                    check_eq("wb_addra", 64'(wb_addra), 64'(e.addr));
                    check_eq("wb_dina", wb_dina, e.data);
                    check_eq("wb_wea", 64'(wb_wea), 64'hFF);
                end
            end else begin
                check_eq("wb_wea_idle", 64'(wb_wea), 64'd0);
            end
            if (in_ena) begin
                if (sb_q.size() == 0) begin
                    check_eq("in_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("in_port_sel", 64'd1, 64'(e.is_in));
                    check_eq("in_addra", 64'(in_addra), 64'(e.addr));
                    check_eq("in_dina", in_dina, e.data);
                    check_eq("in_wea", 64'(in_wea), 64'hFF);
                    if (e.is_in && e.addr == 14'(I_WORDS - 1)) nxt = 1'b1;
                end
            end else begin
                check_eq("in_wea_idle", 64'(in_wea), 64'd0);
            end
            exp_start = nxt;
        end
    end

    task automatic start_load();
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        check_eq("busy_on", 64'(busy), 64'd1);
    endtask

    task automatic send_word(input int k, input logic [63:0] d, input bit gaps);
        exp_t e;
        int   w;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                @(posedge clk); #1;
            end
        end
        e.is_in = (k >= W_WORDS);
        e.addr  = (k >= W_WORDS) ? 14'(k - W_WORDS) : 14'(k);
        e.data  = d;
        sb_q.push_back(e);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        w = 0;
        while (w < 100) begin
            @(negedge clk);
            if (s_if.s_ready) break;
            w++;
        end
        if (w >= 100) check_eq("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_if.s_valid = 1'b0;
    endtask

    task automatic finish_load(input int start_before, input int done_before);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!core_start && w < 50);
        if (!core_start) check_eq("start_timeout", 64'd0, 64'd1);
        repeat (20) @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
        check_eq("load_done_pulse", 64'(load_done), 64'd1);
        check_eq("busy_off", 64'(busy), 64'd0);
        check_eq("s_ready_off", 64'(s_if.s_ready), 64'd0);
        @(negedge clk);
        check_eq("load_done_single", 64'(load_done), 64'd0);
        check_eq("start_count", 64'(n_start), 64'(start_before + 1));
        check_eq("done_count", 64'(n_done), 64'(done_before + 1));
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic run_load(input logic [63:0] base, input bit gaps, input bit inject);
        int s0;
        int d0;
        s0 = n_start;
        d0 = n_done;
        start_load();
        for (int k = 0; k < W_WORDS + I_WORDS; k++) begin
            // Stray core_done while loading weights, stray load_req while loading inputs.
            if (inject && k == 5) core_done = 1'b1;
            if (inject && k == W_WORDS + 8) load_req = 1'b1;
            send_word(k, base + 64'(k), gaps);
            core_done = 1'b0;
            load_req  = 1'b0;
        end
        finish_load(s0, d0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_start = 0;
        n_done = 0;
        exp_start = 1'b0;
        rst = 1'b0;
        load_req = 1'b0;
        core_done = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data = 64'd0;
        #2 rst = 1'b1;
        #1 check_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // A word offered while idle must not be consumed.
        s_if.s_valid = 1'b1;
        s_if.s_data = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("idle_s_ready", 64'(s_if.s_ready), 64'd0);
        end
        @(posedge clk); #1;
        s_if.s_valid = 1'b0;
        check_eq("idle_busy", 64'(busy), 64'd0);

        run_load(64'd0, 1'b0, 1'b1);
        run_load(64'h1000, 1'b1, 1'b0);

        // Asynchronous reset after ten weight beats, then a fresh load from address 0.
        start_load();
        for (int k = 0; k < 10; k++) send_word(k, 64'h2000 + 64'(k), 1'b0);
        #1 rst = 1'b1;
        #1 check_quiet("midload_reset");
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_load(64'h3000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
